ecc_point_ctrl: RTL and testbench

ECC_POINT_CTRL -- requirements
Module: ecc_point_ctrl

---
 rtl/ecc_point_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ecc_point_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_ctrl.sv
// Elliptic-curve point add/double sequencer driving an external GF(p) field unit.
// Runs a fixed micro-program of field ops; only equality compares are done locally.
module ecc_point_ctrl #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            mode,
  input  logic [SIZE-1:0] x1,
  input  logic [SIZE-1:0] y1,
  input  logic [SIZE-1:0] x2,
  input  logic [SIZE-1:0] y2,
  input  logic [SIZE-1:0] prime,
  input  logic [SIZE-1:0] curve_a,
  output logic            busy,
  output logic            done,
  output logic            inf,
  output logic            err,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] y3,
  output logic [SIZE-1:0] gf_in_0,
  output logic [SIZE-1:0] gf_in_1,
  output logic [1:0]      gf_op,
  output logic            gf_start,
  input  logic [SIZE-1:0] gf_result,
  input  logic            gf_done
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, FIN} state_t;
  typedef enum logic [3:0] {S_X1, S_Y1, S_X2, S_Y2, S_A, S_L, S_T0, S_T1, S_X3} src_t;
  typedef enum logic [2:0] {D_L, D_T0, D_T1, D_X3, D_Y3} dst_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] r_x1, r_y1, r_x2, r_y2, r_prime, r_a;
  logic [SIZE-1:0] r_l, r_t0, r_t1;
  logic            r_dbl;
  logic [3:0]      step;
  logic [WW-1:0]   wait_cnt;

  logic            unused_prime;
  assign unused_prime = ^r_prime;

  logic [1:0] p_op;
  src_t       p_s0, p_s1;
  dst_t       p_dst;
  logic       p_last;
  logic       eq_x, eq_y, chk_inf, tmo, op_act;

  assign eq_x    = (r_x1 == r_x2);
  assign eq_y    = (r_y1 == r_y2);
  // An add of equal points falls through to the double program, so its y1==0 case is also infinity.
  assign chk_inf = (!r_dbl && eq_x && !eq_y) || ((r_dbl || eq_x) && (r_y1 == '0));
  assign tmo     = (wait_cnt == WW'(TIMEOUT - 1));

  always_comb begin
    p_op  = OP_ADD;
    p_s0  = S_X1;
    p_s1  = S_X1;
    p_dst = D_T0;
    case ({r_dbl, step})
      5'h00: begin p_op = OP_SUB; p_s0 = S_Y2; p_s1 = S_Y1; p_dst = D_T0; end
      5'h01: begin p_op = OP_SUB; p_s0 = S_X2; p_s1 = S_X1; p_dst = D_T1; end
      5'h02: begin p_op = OP_DIV; p_s0 = S_T0; p_s1 = S_T1; p_dst = D_L;  end
      5'h03: begin p_op = OP_MUL; p_s0 = S_L;  p_s1 = S_L;  p_dst = D_T0; end
      5'h04: begin p_op = OP_SUB; p_s0 = S_T0; p_s1 = S_X1; p_dst = D_T0; end
      5'h05: begin p_op = OP_SUB; p_s0 = S_T0; p_s1 = S_X2; p_dst = D_X3; end
      5'h06: begin p_op = OP_SUB; p_s0 = S_X1; p_s1 = S_X3; p_dst = D_T1; end
      5'h07: begin p_op = OP_MUL; p_s0 = S_L;  p_s1 = S_T1; p_dst = D_T1; end
      5'h08: begin p_op = OP_SUB; p_s0 = S_T1; p_s1 = S_Y1; p_dst = D_Y3; end
      5'h10: begin p_op = OP_MUL; p_s0 = S_X1; p_s1 = S_X1; p_dst = D_T0; end
      5'h11: begin p_op = OP_ADD; p_s0 = S_T0; p_s1 = S_T0; p_dst = D_T1; end
      5'h12: begin p_op = OP_ADD; p_s0 = S_T1; p_s1 = S_T0; p_dst = D_T0; end
      5'h13: begin p_op = OP_ADD; p_s0 = S_T0; p_s1 = S_A;  p_dst = D_T0; end
      5'h14: begin p_op = OP_ADD; p_s0 = S_Y1; p_s1 = S_Y1; p_dst = D_T1; end
      5'h15: begin p_op = OP_DIV; p_s0 = S_T0; p_s1 = S_T1; p_dst = D_L;  end
      5'h16: begin p_op = OP_MUL; p_s0 = S_L;  p_s1 = S_L;  p_dst = D_T0; end
      5'h17: begin p_op = OP_SUB; p_s0 = S_T0; p_s1 = S_X1; p_dst = D_T0; end
      5'h18: begin p_op = OP_SUB; p_s0 = S_T0; p_s1 = S_X1; p_dst = D_X3; end
      5'h19: begin p_op = OP_SUB; p_s0 = S_X1; p_s1 = S_X3; p_dst = D_T1; end
      5'h1a: begin p_op = OP_MUL; p_s0 = S_L;  p_s1 = S_T1; p_dst = D_T1; end
      5'h1b: begin p_op = OP_SUB; p_s0 = S_T1; p_s1 = S_Y1; p_dst = D_Y3; end
      default: ;
    endcase
  end

  assign p_last = r_dbl ? (step == 4'd11) : (step == 4'd8);

  function automatic logic [SIZE-1:0] src_val(input src_t s);
    case (s)
      S_X1:    return r_x1;
      S_Y1:    return r_y1;
      S_X2:    return r_x2;
      S_Y2:    return r_y2;
      S_A:     return r_a;
      S_L:     return r_l;
      S_T0:    return r_t0;
      S_T1:    return r_t1;
      S_X3:    return x3;
      default: return '0;
    endcase
  endfunction

  // Operands come straight from registers that only change on gf_done, so they hold through WAIT.
  assign op_act   = (state == ISSUE) || (state == WAIT);
  assign gf_op    = op_act ? p_op : 2'd0;
  assign gf_in_0  = op_act ? src_val(p_s0) : '0;
  assign gf_in_1  = op_act ? src_val(p_s1) : '0;
  assign gf_start = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: state_nxt = chk_inf ? FIN : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (gf_done)  state_nxt = p_last ? FIN : ISSUE;
        else if (tmo) state_nxt = FIN;
      end
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0; r_prime <= '0; r_a <= '0;
      r_l <= '0; r_t0 <= '0; r_t1 <= '0; r_dbl <= 1'b0;
      step <= '0; wait_cnt <= '0;
      x3 <= '0; y3 <= '0; inf <= 1'b0; err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r_x1 <= x1; r_y1 <= y1; r_x2 <= x2; r_y2 <= y2;
          r_prime <= prime; r_a <= curve_a; r_dbl <= mode;
          x3 <= '0; y3 <= '0; inf <= 1'b0; err <= 1'b0;
          step <= '0;
        end
        CHECK: begin
          if (chk_inf)   inf   <= 1'b1;
          else if (eq_x) r_dbl <= 1'b1;
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (gf_done) begin
            case (p_dst)
              D_L:     r_l  <= gf_result;
              D_T0:    r_t0 <= gf_result;
              D_T1:    r_t1 <= gf_result;
              D_X3:    x3   <= gf_result;
              D_Y3:    y3   <= gf_result;
              default: ;
            endcase
            step <= step + 4'd1;
          end else if (tmo) begin
            err <= 1'b1;
            x3  <= '0;
            y3  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Bench for ecc_point_ctrl: behavioural GF(p) field unit with random latency plus
// an affine-point reference model computed directly with modular arithmetic.
module tb_ecc_point_ctrl;
  localparam int SIZE    = 32;
  localparam int TIMEOUT = 255;

  logic i_clk = 1'b0;
  logic i_rst, start, mode;
  logic [SIZE-1:0] x1, y1, x2, y2, prime, curve_a;
  logic busy, done, inf, err, gf_start, gf_done;
  logic [SIZE-1:0] x3, y3, gf_in_0, gf_in_1, gf_result;
  logic [1:0] gf_op;

  ecc_point_ctrl #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .start(start), .mode(mode),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .prime(prime), .curve_a(curve_a),
    .busy(busy), .done(done), .inf(inf), .err(err), .x3(x3), .y3(y3),
    .gf_in_0(gf_in_0), .gf_in_1(gf_in_1), .gf_op(gf_op), .gf_start(gf_start),
    .gf_result(gf_result), .gf_done(gf_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  bit fu_en = 1'b1;
  bit fu_busy = 1'b0;
  int fu_cnt;
  logic [SIZE-1:0] fu_res, cap0, cap1, fu_prime;
  logic [1:0] capop;
  int n_starts, sum_cost, stab_err, dbl_start;

  function automatic longint unsigned mpow(longint unsigned b, longint unsigned e, longint unsigned p);
    longint unsigned r = 1;
    b = b % p;
    while (e != 0) begin
      if (e[0]) r = (r * b) % p;
      b = (b * b) % p;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned mdiv(longint unsigned a, longint unsigned b, longint unsigned p);
    if (b % p == 0) return 0;
    return (a * mpow(b, p - 2, p)) % p;
  endfunction

  function automatic logic [SIZE-1:0] fu_calc(logic [1:0] op, longint unsigned a, longint unsigned b,
                                              longint unsigned p);
    case (op)
      2'd0:    return SIZE'((a + b) % p);
      2'd1:    return SIZE'((a + p - b) % p);
      2'd2:    return SIZE'((a * b) % p);
      default: return SIZE'(mdiv(a, b, p));
    endcase
  endfunction

  // Field unit: accepts gf_start, answers after 1..4 cycles, records operand stability while waiting.
  initial begin
    gf_done = 1'b0;
    gf_result = '0;
    forever begin
      @(negedge i_clk);
      gf_done = 1'b0;
      if (i_rst === 1'b1) begin
        fu_busy = 1'b0;
      end else if (fu_busy) begin
        if (gf_start === 1'b1) dbl_start++;
        if (gf_op !== capop || gf_in_0 !== cap0 || gf_in_1 !== cap1) stab_err++;
        fu_cnt--;
        if (fu_cnt == 0) begin
          gf_done = 1'b1;
          gf_result = fu_res;
          fu_busy = 1'b0;
        end
      end else if (gf_start === 1'b1) begin
        n_starts++;
        capop = gf_op; cap0 = gf_in_0; cap1 = gf_in_1;
        fu_cnt = $urandom_range(1, 4);
        sum_cost += 1 + fu_cnt;
        fu_res = fu_calc(gf_op, cap0, cap1, fu_prime);
        fu_busy = fu_en;
      end
    end
  end

  // Reference: affine point add/double over GF(p).
  task automatic ref_point(input logic m, input longint unsigned ax1, ay1, ax2, ay2, p, a,
                           output logic [SIZE-1:0] ex, ey, output logic einf, output int nops);
    longint unsigned l, rx, ry;
    ex = '0; ey = '0; einf = 1'b0; nops = 0;
    if (!m && ax1 == ax2 && ay1 != ay2) begin
      einf = 1'b1;
    end else if ((m || ax1 == ax2) && ay1 == 0) begin
      einf = 1'b1;
    end else begin
      if (m || ax1 == ax2) begin
        l = mdiv((3 * ((ax1 * ax1) % p) + a) % p, (2 * ay1) % p, p);
        rx = ((l * l) % p + 2 * p - 2 * ax1) % p;
        nops = 12;
      end else begin
        l = mdiv((ay2 + p - ay1) % p, (ax2 + p - ax1) % p, p);
        rx = ((l * l) % p + 2 * p - ax1 - ax2) % p;
        nops = 9;
      end
      ry = ((l * ((ax1 + p - rx) % p)) % p + p - ay1) % p;
      ex = SIZE'(rx);
      ey = SIZE'(ry);
    end
  endtask

  task automatic run_op(input logic m, input logic [SIZE-1:0] ax1, ay1, ax2, ay2, ap, aa,
                        input int poke, output logic [SIZE-1:0] rx, ry,
                        output logic rinf, rerr, output int cyc, output bit got);
    @(negedge i_clk);
    mode = m; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; prime = ap; curve_a = aa;
    fu_prime = ap;
    n_starts = 0; sum_cost = 0; stab_err = 0; dbl_start = 0;
    start = 1'b1;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge i_clk);
      cyc = c;
      start = (c == poke);
      if (c == poke) begin
        mode = ~m; x1 = ~ax1; y1 = ~ay1; x2 = ax1; y2 = ay1;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    rx = x3; ry = y3; rinf = inf; rerr = err;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({inf, err} !== 2'b00) begin errors++; $display("FAIL reset_inf_err got %b want 00", {inf, err}); end
    checks++; if (gf_start !== 1'b0) begin errors++; $display("FAIL reset_gf_start got %b want 0", gf_start); end
    checks++; if ({x3, y3} !== '0) begin errors++; $display("FAIL reset_xy got %h %h want 0 0", x3, y3); end
    checks++; if ({gf_in_0, gf_in_1, gf_op} !== '0) begin
      errors++; $display("FAIL reset_gf_bus got %h %h %h want 0", gf_in_0, gf_in_1, gf_op);
    end
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_double();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got;
    run_op(1'b1, 5, 1, 0, 0, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got) begin errors++; $display("FAIL dbl_done got none want pulse"); end
    checks++; if ({rx, ry} !== {32'd6, 32'd3}) begin errors++; $display("FAIL dbl_xy got %0d,%0d want 6,3", rx, ry); end
    checks++; if ({rinf, rerr} !== 2'b00) begin errors++; $display("FAIL dbl_flags got %b want 00", {rinf, rerr}); end
    checks++; if (n_starts != 12) begin errors++; $display("FAIL dbl_starts got %0d want 12", n_starts); end
    checks++; if (cyc != 2 + sum_cost) begin errors++; $display("FAIL dbl_latency got %0d want %0d", cyc, 2 + sum_cost); end
    checks++; if (stab_err != 0 || dbl_start != 0) begin
      errors++; $display("FAIL dbl_stable got %0d/%0d want 0/0", stab_err, dbl_start);
    end
    @(negedge i_clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL dbl_after got %b want 00", {busy, done}); end
  endtask

  task automatic test_add();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got;
    run_op(1'b0, 5, 1, 6, 3, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || {rx, ry} !== {32'd10, 32'd6}) begin
      errors++; $display("FAIL add_xy got %0d,%0d done=%0d want 10,6", rx, ry, got);
    end
    checks++; if (n_starts != 9) begin errors++; $display("FAIL add_starts got %0d want 9", n_starts); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL add_stable got %0d want 0", stab_err); end
    checks++; if (cyc != 2 + sum_cost) begin errors++; $display("FAIL add_latency got %0d want %0d", cyc, 2 + sum_cost); end
  endtask

  task automatic test_inf();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got;
    run_op(1'b0, 5, 1, 5, 16, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || rinf !== 1'b1 || {rx, ry} !== '0) begin
      errors++; $display("FAIL inf_result got inf=%b %0d,%0d want inf=1 0,0", rinf, rx, ry);
    end
    checks++; if (cyc != 2) begin errors++; $display("FAIL inf_latency got %0d want 2", cyc); end
    checks++; if (n_starts != 0) begin errors++; $display("FAIL inf_starts got %0d want 0", n_starts); end
    run_op(1'b0, 5, 1, 5, 1, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || rinf !== 1'b0 || {rx, ry} !== {32'd6, 32'd3}) begin
      errors++; $display("FAIL add_equal got inf=%b %0d,%0d want inf=0 6,3", rinf, rx, ry);
    end
    checks++; if (n_starts != 12) begin errors++; $display("FAIL add_equal_starts got %0d want 12", n_starts); end
    // Add-of-equal points with y==0 must come out as infinity.
    run_op(1'b0, 4, 0, 4, 0, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || rinf !== 1'b1 || cyc != 2 || n_starts != 0) begin
      errors++; $display("FAIL add_equal_y0 got inf=%b cyc=%0d starts=%0d want inf=1 cyc=2 starts=0", rinf, cyc, n_starts);
    end
  endtask

  task automatic test_busy_start();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got;
    run_op(1'b1, 5, 1, 0, 0, 17, 2, 5, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || {rx, ry} !== {32'd6, 32'd3} || n_starts != 12) begin
      errors++; $display("FAIL busy_start got %0d,%0d starts=%0d want 6,3 starts=12", rx, ry, n_starts);
    end
    repeat (3) @(negedge i_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got;
    fu_en = 1'b0;
    run_op(1'b0, 5, 1, 6, 3, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    fu_en = 1'b1;
    checks++; if (!got || rerr !== 1'b1 || {rx, ry} !== '0) begin
      errors++; $display("FAIL timeout_result got err=%b %0d,%0d done=%0d want err=1 0,0", rerr, rx, ry, got);
    end
    checks++; if (cyc != 3 + TIMEOUT) begin errors++; $display("FAIL timeout_latency got %0d want %0d", cyc, 3 + TIMEOUT); end
    checks++; if (n_starts != 1) begin errors++; $display("FAIL timeout_starts got %0d want 1", n_starts); end
  endtask

  task automatic test_reset_mid_op();
    logic [SIZE-1:0] rx, ry; logic rinf, rerr; int cyc; bit got; int ndone;
    @(negedge i_clk);
    mode = 1'b1; x1 = 5; y1 = 1; x2 = 0; y2 = 0; prime = 17; curve_a = 2; fu_prime = 17;
    n_starts = 0; sum_cost = 0;
    start = 1'b1;
    @(negedge i_clk);
    start = 1'b0;
    for (int c = 0; c < 200 && n_starts < 3; c++) @(negedge i_clk);
    @(negedge i_clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b want 1", busy); end
    i_rst = 1'b1;
    #1;
    checks++; if ({busy, done, inf, err, gf_start, gf_op} !== '0 || {x3, y3, gf_in_0, gf_in_1} !== '0) begin
      errors++; $display("FAIL midop_reset_outs got busy=%b done=%b x3=%0d y3=%0d gf=%h/%h", busy, done, x3, y3, gf_in_0, gf_in_1);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midop_no_done got %0d active cycles want 0", ndone); end
    run_op(1'b1, 5, 1, 0, 0, 17, 2, 0, rx, ry, rinf, rerr, cyc, got);
    checks++; if (!got || {rx, ry} !== {32'd6, 32'd3} || {rinf, rerr} !== 2'b00) begin
      errors++; $display("FAIL midop_rerun got %0d,%0d inf=%b err=%b want 6,3 0 0", rx, ry, rinf, rerr);
    end
  endtask

  task automatic test_random();
    longint unsigned primes[5] = '{17, 97, 251, 65521, 2147483647};
    logic [SIZE-1:0] rx, ry, ex, ey; logic rinf, rerr, einf; int cyc, nops; bit got;
    longint unsigned p, a, ax1, ay1, ax2, ay2;
    logic m;
    for (int i = 0; i < 30; i++) begin
      p = primes[$urandom_range(0, 4)];
      a = $urandom % p;
      m = 1'($urandom_range(0, 1));
      ax1 = $urandom % p; ay1 = $urandom % p;
      ax2 = $urandom % p; ay2 = $urandom % p;
      case ($urandom_range(0, 4))
        0: begin ax2 = ax1; ay2 = ay1; end
        1: begin ax2 = ax1; ay2 = (p - ay1) % p; end
        2: ay1 = 0;
        default: ;
      endcase
      ref_point(m, ax1, ay1, ax2, ay2, p, a, ex, ey, einf, nops);
      run_op(m, SIZE'(ax1), SIZE'(ay1), SIZE'(ax2), SIZE'(ay2), SIZE'(p), SIZE'(a), 0,
             rx, ry, rinf, rerr, cyc, got);
      checks++; if (!got || {rx, ry} !== {ex, ey} || rinf !== einf || rerr !== 1'b0) begin
        errors++; $display("FAIL rand_%0d_result got %0d,%0d inf=%b err=%b want %0d,%0d inf=%b", i, rx, ry, rinf, rerr, ex, ey, einf);
      end
      checks++; if (n_starts != nops || stab_err != 0 || cyc != (einf ? 2 : 2 + sum_cost)) begin
        errors++; $display("FAIL rand_%0d_timing got starts=%0d cyc=%0d unstable=%0d want starts=%0d", i, n_starts, cyc, stab_err, nops);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; start = 1'b0; mode = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; prime = 17; curve_a = '0; fu_prime = 17;
    n_starts = 0; sum_cost = 0; stab_err = 0; dbl_start = 0;
    test_reset();
    test_double();
    test_add();
    test_inf();
    test_busy_start();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
